// File: rtl/vjtag_mem_bridge.sv
// vjtag_mem_bridge: clk-side companion of the virtual JTAG DR interface.
// Converts TCK-domain update/capture pulses into memory transactions on clk.
//
// Ports
//   clk           in   system clock, all memory-side logic
//   aclr          in   asynchronous active-low reset (both domains)
//   tck           in   JTAG TCK
//   jtag_wr_upd   in   tck pulse: Update-DR with IR=WRITE
//   jtag_addr_upd in   tck pulse: Update-DR with IR=SET_ADDR
//   jtag_rd_cap   in   tck pulse: Capture-DR with IR=READ
//   jtag_wdata    in   write data, quasi-static between WRITE updates
//   jtag_addr     in   address, quasi-static between SET_ADDR updates
//   jtag_rdata    out  prefetched read word, to JTAG data_in
//   mem_req       out  memory request, held until mem_ack
//   mem_we        out  1 = write, 0 = read
//   mem_addr      out  current address
//   mem_wdata     out  write data
//   mem_ack       in   one-cycle completion
//   mem_rdata     in   read data, valid with mem_ack
//   busy          out  FSM active or any event pending
//   overrun       out  sticky: an event hit its own still-pending flag

module vjtag_mem_bridge #(
   parameter int DW    = 8,
   parameter int AW    = 18,
   parameter int DEPTH = 2**AW
) (
   input  logic          clk,
   input  logic          aclr,
   input  logic          tck,
   input  logic          jtag_wr_upd,
   input  logic          jtag_addr_upd,
   input  logic          jtag_rd_cap,
   input  logic [DW-1:0] jtag_wdata,
   input  logic [AW-1:0] jtag_addr,
   output logic [DW-1:0] jtag_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy,
   output logic          overrun
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // TCK domain: one toggle flop per event type, nothing else
   // ------------------------------------------------------------------
   logic t_wr_q, t_wr_d;
   logic t_addr_q, t_addr_d;
   logic t_rd_q, t_rd_d;

   always_comb begin
      t_wr_d   = t_wr_q ^ jtag_wr_upd;
      t_addr_d = t_addr_q ^ jtag_addr_upd;
      t_rd_d   = t_rd_q ^ jtag_rd_cap;
   end

   always_ff @(posedge tck or negedge aclr) begin
      if (!aclr) begin
         t_wr_q   <= 1'b0;
         t_addr_q <= 1'b0;
         t_rd_q   <= 1'b0;
      end else begin
         t_wr_q   <= t_wr_d;
         t_addr_q <= t_addr_d;
         t_rd_q   <= t_rd_d;
      end
   end

   // ------------------------------------------------------------------
   // CDC: 2-flop synchronizer plus one flop for edge detection.
   // Bit 0 is the metastable stage; events come from bits 1 and 2.
   // ------------------------------------------------------------------
   logic [2:0] wr_sync_q, wr_sync_d;
   logic [2:0] addr_sync_q, addr_sync_d;
   logic [2:0] rd_sync_q, rd_sync_d;
   logic       ev_wr, ev_addr, ev_rd;

   always_comb begin
      wr_sync_d   = {wr_sync_q[1:0], t_wr_q};
      addr_sync_d = {addr_sync_q[1:0], t_addr_q};
      rd_sync_d   = {rd_sync_q[1:0], t_rd_q};
      ev_wr       = wr_sync_q[2] ^ wr_sync_q[1];
      ev_addr     = addr_sync_q[2] ^ addr_sync_q[1];
      ev_rd       = rd_sync_q[2] ^ rd_sync_q[1];
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         wr_sync_q   <= '0;
         addr_sync_q <= '0;
         rd_sync_q   <= '0;
      end else begin
         wr_sync_q   <= wr_sync_d;
         addr_sync_q <= addr_sync_d;
         rd_sync_q   <= rd_sync_d;
      end
   end

   // ------------------------------------------------------------------
   // Pending flags and sticky overrun
   // ------------------------------------------------------------------
   logic p_wr_q, p_wr_d;
   logic p_addr_q, p_addr_d;
   logic p_rd_q, p_rd_d;
   logic clr_wr, clr_addr, clr_rd;
   logic overrun_q, overrun_d;

   // A new event wins over a same-cycle clear so it is never lost.
   always_comb begin
      p_wr_d    = (p_wr_q & ~clr_wr) | ev_wr;
      p_addr_d  = (p_addr_q & ~clr_addr) | ev_addr;
      p_rd_d    = (p_rd_q & ~clr_rd) | ev_rd;
      overrun_d = overrun_q
                | (ev_wr & p_wr_q)
                | (ev_addr & p_addr_q)
                | (ev_rd & p_rd_q);
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         p_wr_q    <= 1'b0;
         p_addr_q  <= 1'b0;
         p_rd_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         p_wr_q    <= p_wr_d;
         p_addr_q  <= p_addr_d;
         p_rd_q    <= p_rd_d;
         overrun_q <= overrun_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   state_t state_q, state_d;

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next state
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (p_addr_q) begin
               state_d = ST_READ;
            end else if (p_wr_q) begin
               state_d = ST_WRITE;
            end else if (p_rd_q) begin
               state_d = ST_READ;
            end
         end
         ST_WRITE,
         ST_READ: begin
            if (mem_ack) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: outputs and datapath updates
   // ------------------------------------------------------------------
   logic [AW-1:0] cur_addr_q, cur_addr_d;
   logic [AW-1:0] addr_inc;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [DW-1:0] rdata_q, rdata_d;
   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;

   // Explicit wrap so a DEPTH below 2**AW still folds back to 0.
   always_comb begin
      if (cur_addr_q == AW'(DEPTH - 1)) begin
         addr_inc = '0;
      end else begin
         addr_inc = cur_addr_q + AW'(1);
      end
   end

   always_comb begin
      clr_wr     = 1'b0;
      clr_addr   = 1'b0;
      clr_rd     = 1'b0;
      cur_addr_d = cur_addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      unique case (state_q)
         ST_IDLE: begin
            if (p_addr_q) begin
               clr_addr   = 1'b1;
               cur_addr_d = jtag_addr;
            end else if (p_wr_q) begin
               clr_wr  = 1'b1;
               wdata_d = jtag_wdata;
            end else if (p_rd_q) begin
               clr_rd     = 1'b1;
               cur_addr_d = addr_inc;
            end
         end
         ST_WRITE: begin
            if (mem_ack) begin
               cur_addr_d = addr_inc;
            end
         end
         ST_READ: begin
            if (mem_ack) begin
               rdata_d = mem_rdata;
            end
         end
         default: ;
      endcase
      // Request lines follow the next state so they are true flops.
      mem_req_d = (state_d != ST_IDLE);
      mem_we_d  = (state_d == ST_WRITE);
   end

   always_ff @(posedge clk or negedge aclr) begin
      if (!aclr) begin
         cur_addr_q <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
      end else begin
         cur_addr_q <= cur_addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         mem_req_q  <= mem_req_d;
         mem_we_q   <= mem_we_d;
      end
   end

   always_comb begin
      jtag_rdata = rdata_q;
      mem_req    = mem_req_q;
      mem_we     = mem_we_q;
      mem_addr   = cur_addr_q;
      mem_wdata  = wdata_q;
      overrun    = overrun_q;
      busy       = (state_q != ST_IDLE) | p_wr_q | p_addr_q | p_rd_q;
   end

endmodule

// File: tb/tb_vjtag_mem_bridge.sv
// tb_vjtag_mem_bridge: directed bench for vjtag_mem_bridge.
// Host-level transaction model plus a memory slave that checks every request.

`timescale 1ns/1ps

module tb_vjtag_mem_bridge;

   localparam int DW    = 8;
   localparam int AW    = 18;
   localparam int DEPTH = 2**AW;

   logic          clk = 1'b0;
   logic          tck = 1'b0;
   logic          aclr = 1'b0;
   logic          jtag_wr_upd = 1'b0;
   logic          jtag_addr_upd = 1'b0;
   logic          jtag_rd_cap = 1'b0;
   logic [DW-1:0] jtag_wdata = '0;
   logic [AW-1:0] jtag_addr = '0;
   logic [DW-1:0] jtag_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ack = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy;
   logic          overrun;

   vjtag_mem_bridge #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .aclr          (aclr),
      .tck           (tck),
      .jtag_wr_upd   (jtag_wr_upd),
      .jtag_addr_upd (jtag_addr_upd),
      .jtag_rd_cap   (jtag_rd_cap),
      .jtag_wdata    (jtag_wdata),
      .jtag_addr     (jtag_addr),
      .jtag_rdata    (jtag_rdata),
      .mem_req       (mem_req),
      .mem_we        (mem_we),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .busy          (busy),
      .overrun       (overrun)
   );

   always #5 clk = ~clk;
   always #17 tck = ~tck;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } txn_t;

   txn_t          exp_q[$];
   txn_t          cur;
   logic [DW-1:0] mem [int];
   logic [AW-1:0] host_addr = '0;
   logic [DW-1:0] m_rdata = '0;
   logic [AW-1:0] m_addr = '0;
   int            n_cmp = 0;
   int            n_bad = 0;
   int            ack_dly = 0;
   bit            ack_hold = 1'b0;
   bit            in_txn = 1'b0;
   int            wait_cnt = 0;
   int            n_writes = 0;

   function automatic logic [DW-1:0] memval(input logic [AW-1:0] a);
      int k;
      k = int'(a);
      if (mem.exists(k)) return mem[k];
      return a[7:0] ^ 8'hC3;
   endfunction

   function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
      int n;
      n = (int'(a) + 1) % DEPTH;
      return AW'(n);
   endfunction

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
      end
   endtask

   // Memory slave and per-cycle comparison against the host model.
   always @(negedge clk) begin
      if (!aclr) begin
         mem_ack   = 1'b0;
         in_txn    = 1'b0;
         wait_cnt  = 0;
         exp_q.delete();
         m_rdata   = '0;
         m_addr    = '0;
         host_addr = '0;
      end else begin
         mem_ack = 1'b0;
         if (mem_req) begin
            check("busy_with_req", busy, 1);
            if (!in_txn) begin
               in_txn   = 1'b1;
               wait_cnt = 0;
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL unexpected_req: got we=%0d addr=0x%0h expected none",
                           mem_we, mem_addr);
                  cur = '{we: mem_we, addr: mem_addr, data: mem_wdata};
               end else begin
                  cur = exp_q.pop_front();
                  check("req_we", mem_we, cur.we);
                  check("req_addr", mem_addr, cur.addr);
                  if (cur.we) check("req_wdata", mem_wdata, cur.data);
               end
            end else begin
               check("hold_we", mem_we, cur.we);
               check("hold_addr", mem_addr, cur.addr);
            end
            if (!ack_hold) begin
               if (wait_cnt >= ack_dly) begin
                  mem_ack = 1'b1;
                  if (cur.we) begin
                     mem[int'(cur.addr)] = mem_wdata;
                     n_writes++;
                     m_addr = next_addr(cur.addr);
                  end else begin
                     mem_rdata = memval(cur.addr);
                     m_rdata   = mem_rdata;
                     m_addr    = cur.addr;
                  end
                  in_txn = 1'b0;
               end
               wait_cnt++;
            end
         end else begin
            check("idle_rdata", jtag_rdata, m_rdata);
            check("idle_addr", mem_addr, m_addr);
         end
      end
   end

   task automatic tck_pulse(input bit wr, input bit ad, input bit rd);
      @(negedge tck);
      jtag_wr_upd   = wr;
      jtag_addr_upd = ad;
      jtag_rd_cap   = rd;
      @(negedge tck);
      jtag_wr_upd   = 1'b0;
      jtag_addr_upd = 1'b0;
      jtag_rd_cap   = 1'b0;
   endtask

   task automatic set_addr(input logic [AW-1:0] a);
      jtag_addr = a;
      exp_q.push_back('{we: 1'b0, addr: a, data: '0});
      host_addr = a;
      tck_pulse(1'b0, 1'b1, 1'b0);
   endtask

   task automatic host_write(input logic [DW-1:0] d);
      jtag_wdata = d;
      exp_q.push_back('{we: 1'b1, addr: host_addr, data: d});
      host_addr = next_addr(host_addr);
      tck_pulse(1'b1, 1'b0, 1'b0);
   endtask

   task automatic read_cap();
      host_addr = next_addr(host_addr);
      exp_q.push_back('{we: 1'b0, addr: host_addr, data: '0});
      tck_pulse(1'b0, 1'b0, 1'b1);
   endtask

   task automatic wait_idle(input string name);
      repeat (12) @(negedge clk);
      for (int i = 0; i < 400 && busy; i++) @(negedge clk);
      check(name, busy, 0);
      check({name, "_req"}, mem_req, 0);
      check({name, "_queue"}, exp_q.size(), 0);
   endtask

   task automatic wait_req(input string name);
      for (int i = 0; i < 60 && !mem_req; i++) @(negedge clk);
      check(name, mem_req, 1);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_req"}, mem_req, 0);
      check({tag, "_we"}, mem_we, 0);
      check({tag, "_addr"}, mem_addr, 0);
      check({tag, "_wdata"}, mem_wdata, 0);
      check({tag, "_rdata"}, jtag_rdata, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_ovr"}, overrun, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w0;
      aclr = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("rst");
      aclr = 1'b1;
      repeat (4) @(negedge clk);

      // Single prefetch after SET_ADDR
      mem[32'h10] = 8'hA5;
      ack_dly = 0;
      set_addr(18'h00010);
      wait_idle("t2_idle");
      check("t2_rdata", jtag_rdata, 8'hA5);
      check("t2_addr", mem_addr, 18'h00010);

      // Burst write with post-increment
      set_addr(18'h00100);
      wait_idle("t3_sa");
      host_write(8'h11);
      wait_idle("t3_w0");
      host_write(8'h22);
      wait_idle("t3_w1");
      host_write(8'h33);
      wait_idle("t3_w2");
      check("t3_m100", memval(18'h00100), 8'h11);
      check("t3_m101", memval(18'h00101), 8'h22);
      check("t3_m102", memval(18'h00102), 8'h33);
      check("t3_addr", mem_addr, 18'h00103);
      check("t3_rdata", jtag_rdata, 8'hC3);

      // Reset in the middle of a read
      ack_hold = 1'b1;
      set_addr(18'h00040);
      wait_req("t1_req_up");
      @(posedge clk);
      #2;
      aclr = 1'b0;
      #1;
      check("t1_req_drop", mem_req, 0);
      repeat (3) @(negedge clk);
      check_reset("t1_in");
      ack_hold = 1'b0;
      aclr = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("t1_out");

      // Wrap from DEPTH-1 to 0 on READ capture
      mem[0] = 8'h5E;
      set_addr(AW'(DEPTH - 1));
      wait_idle("t4_sa");
      check("t4_rdata_top", jtag_rdata, 8'h3C);
      read_cap();
      wait_idle("t4_rd");
      check("t4_rdata", jtag_rdata, 8'h5E);
      check("t4_addr", mem_addr, 0);

      // SET_ADDR and WRITE pending together, slow acks
      ack_dly = 5;
      jtag_addr  = 18'h002A0;
      jtag_wdata = 8'h99;
      exp_q.push_back('{we: 1'b0, addr: 18'h002A0, data: '0});
      exp_q.push_back('{we: 1'b1, addr: 18'h002A0, data: 8'h99});
      host_addr = 18'h002A1;
      tck_pulse(1'b1, 1'b1, 1'b0);
      wait_idle("t5_idle");
      check("t5_mem", memval(18'h002A0), 8'h99);
      check("t5_rdata", jtag_rdata, 8'h63);
      check("t5_addr", mem_addr, 18'h002A1);
      check("t5_ovr", overrun, 0);

      // Two WRITE updates while a read stalls
      ack_dly  = 0;
      ack_hold = 1'b1;
      set_addr(18'h00200);
      wait_req("t6_req_up");
      jtag_wdata = 8'h77;
      tck_pulse(1'b1, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      check("t6_ovr_one", overrun, 0);
      jtag_wdata = 8'h88;
      exp_q.push_back('{we: 1'b1, addr: 18'h00200, data: 8'h88});
      host_addr = 18'h00201;
      tck_pulse(1'b1, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      check("t6_ovr", overrun, 1);
      check("t6_busy", busy, 1);
      check("t6_req", mem_req, 1);
      check("t6_we", mem_we, 0);
      w0 = n_writes;
      ack_hold = 1'b0;
      wait_idle("t6_idle");
      check("t6_nwr", n_writes - w0, 1);
      check("t6_mem", memval(18'h00200), 8'h88);
      check("t6_rdata", jtag_rdata, 8'hC3);
      check("t6_addr", mem_addr, 18'h00201);
      check("t6_ovr_sticky", overrun, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
